// File: rtl/pkt_mem_pkg.sv
// Shared constants and TX state encoding for the packet store read side.
package pkt_mem_pkg;

    localparam int unsigned MIN_PACKET_LENGTH = 64;
    localparam int unsigned MAX_PACKET_LENGTH = 1536;
    localparam int unsigned DEPTH_RAM         = 2 * MAX_PACKET_LENGTH;
    localparam int unsigned IFG_CYCLES        = 12;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PREAMBLE_LEN  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLen,
        StSkip,
        StPre,
        StData,
        StIfg
    } tx_state_e;

endpackage

// File: rtl/pkt_rd_addr_gen.sv
// Modulo-depth RAM read pointer: single-step increment or one-cycle add of a length.
module pkt_rd_addr_gen #(
    parameter int unsigned pDEPTH_RAM  = 3072,
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pLEN_WIDTH  = 12
) (
    input  logic                   iclk,
    input  logic                   i_rst_n,
    input  logic                   i_inc,
    input  logic                   i_add,
    input  logic [pLEN_WIDTH-1:0]  i_len,
    output logic [pADDR_WIDTH-1:0] o_ptr
);

    localparam int unsigned SW = ((pADDR_WIDTH > pLEN_WIDTH) ? pADDR_WIDTH : pLEN_WIDTH) + 2;
    localparam logic [SW-1:0] DEPTH1 = SW'(pDEPTH_RAM);
    localparam logic [SW-1:0] DEPTH2 = SW'(2 * pDEPTH_RAM);
    localparam logic [pADDR_WIDTH-1:0] LAST_ADDR = pADDR_WIDTH'(pDEPTH_RAM - 1);

    logic [pADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [SW-1:0]          sum_raw, sum_mod;

    // Lengths are below 2*depth, so the raw sum stays under 3*depth.
    always_comb begin
        sum_raw = SW'(ptr_q) + SW'(i_len);
        if (sum_raw >= DEPTH2) begin
            sum_mod = sum_raw - DEPTH2;
        end else if (sum_raw >= DEPTH1) begin
            sum_mod = sum_raw - DEPTH1;
        end else begin
            sum_mod = sum_raw;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_add) begin
            ptr_d = pADDR_WIDTH'(sum_mod);
        end else if (i_inc) begin
            ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/packet_tx_reader.sv
// Drains one length word per packet and streams preamble, SFD and RAM bytes as an MII-style
// TX stream; bad lengths are skipped by advancing the read pointer.
module packet_tx_reader
    import pkt_mem_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH        = 8,
    parameter int unsigned pMIN_PACKET_LENGHT = MIN_PACKET_LENGTH,
    parameter int unsigned pMAX_PACKET_LENGHT = MAX_PACKET_LENGTH,
    parameter int unsigned pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
    parameter int unsigned pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
    parameter int unsigned pIFG               = IFG_CYCLES
) (
    input  logic                          iclk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_fifo_empty,
    output logic                          o_fifo_rd,
    input  logic [pLEN_WIDTH-1:0]         i_fifo_len,
    output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_addr,
    input  logic [pDATA_WIDTH-1:0]        i_rd_data,
    output logic                          o_tx_en,
    output logic [pDATA_WIDTH-1:0]        o_txd,
    output logic                          o_busy,
    output logic                          o_pkt_done,
    output logic                          o_len_err
);

    localparam int unsigned ADDR_WIDTH = $clog2(pDEPTH_RAM);
    // IDLE, POP and LEN add three silent cycles before the next preamble, so IFG holds for
    // the remainder to give exactly pIFG idle line cycles between back-to-back frames.
    localparam int unsigned IFG_HOLD = (pIFG > 4) ? pIFG - 3 : 1;
    localparam int unsigned IFG_CW   = (IFG_HOLD > 1) ? $clog2(IFG_HOLD) : 1;
    localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN - 1);

    tx_state_e               state_q, state_d;
    logic [2:0]              pre_cnt_q, pre_cnt_d;
    logic [pLEN_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [pLEN_WIDTH-1:0]   r_len_q, r_len_d;
    logic [IFG_CW-1:0]       ifg_cnt_q, ifg_cnt_d;

    logic                    fifo_rd_q, fifo_rd_d;
    logic                    tx_en_q, tx_en_d;
    logic [pDATA_WIDTH-1:0]  txd_q, txd_d;
    logic                    busy_q;
    logic                    pkt_done_q, pkt_done_d;
    logic                    len_err_q, len_err_d;

    logic                    ptr_inc, ptr_add;
    logic                    len_ok;

    assign len_ok = (i_fifo_len >= pLEN_WIDTH'(pMIN_PACKET_LENGHT)) &&
                    (i_fifo_len <= pLEN_WIDTH'(pMAX_PACKET_LENGHT));

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        r_len_d    = r_len_q;
        ifg_cnt_d  = ifg_cnt_q;
        fifo_rd_d  = 1'b0;
        tx_en_d    = 1'b0;
        txd_d      = '0;
        pkt_done_d = 1'b0;
        len_err_d  = 1'b0;
        ptr_inc    = 1'b0;
        ptr_add    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_enable && !i_fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    state_d   = StPop;
                end
            end
            StPop: begin
                state_d = StLen;
            end
            StLen: begin
                r_len_d = i_fifo_len;
                if (len_ok) begin
                    pre_cnt_d = '0;
                    state_d   = StPre;
                end else begin
                    len_err_d = 1'b1;
                    state_d   = StSkip;
                end
            end
            StSkip: begin
                ptr_add = 1'b1;
                state_d = StIdle;
            end
            StPre: begin
                tx_en_d   = 1'b1;
                txd_d     = (pre_cnt_q == PRE_LAST) ? pDATA_WIDTH'(SFD_BYTE)
                                                    : pDATA_WIDTH'(PREAMBLE_BYTE);
                pre_cnt_d = pre_cnt_q + 3'd1;
                // The first RAM address is already on o_rd_addr; step past it so the
                // first data byte lands right behind the SFD.
                if (pre_cnt_q == PRE_LAST) begin
                    ptr_inc    = 1'b1;
                    byte_cnt_d = r_len_q;
                    state_d    = StData;
                end
            end
            StData: begin
                tx_en_d = 1'b1;
                txd_d   = i_rd_data;
                if (byte_cnt_q == pLEN_WIDTH'(1)) begin
                    pkt_done_d = 1'b1;
                    ifg_cnt_d  = IFG_CW'(IFG_HOLD - 1);
                    state_d    = StIfg;
                end else begin
                    ptr_inc    = 1'b1;
                    byte_cnt_d = byte_cnt_q - 1'b1;
                end
            end
            StIfg: begin
                if (ifg_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            r_len_q    <= '0;
            ifg_cnt_q  <= '0;
            fifo_rd_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            txd_q      <= '0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            r_len_q    <= r_len_d;
            ifg_cnt_q  <= ifg_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
            busy_q     <= (state_d != StIdle);
            pkt_done_q <= pkt_done_d;
            len_err_q  <= len_err_d;
        end
    end

    pkt_rd_addr_gen #(
        .pDEPTH_RAM  (pDEPTH_RAM),
        .pADDR_WIDTH (ADDR_WIDTH),
        .pLEN_WIDTH  (pLEN_WIDTH)
    ) u_rd_addr_gen (
        .iclk    (iclk),
        .i_rst_n (i_rst_n),
        .i_inc   (ptr_inc),
        .i_add   (ptr_add),
        .i_len   (r_len_q),
        .o_ptr   (o_rd_addr)
    );

    assign o_fifo_rd  = fifo_rd_q;
    assign o_tx_en    = tx_en_q;
    assign o_txd      = txd_q;
    assign o_busy     = busy_q;
    assign o_pkt_done = pkt_done_q;
    assign o_len_err  = len_err_q;

endmodule

// File: tb/tb_packet_tx_reader.sv
// Bench for packet_tx_reader: FIFO and RAM models, line monitor, and a frame-level reference.
module tb_packet_tx_reader;

    localparam int DEPTH = 3072;

    logic        iclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [11:0] fifo_len = '0;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic        tx_en;
    logic [7:0]  txd;
    logic        busy, pkt_done, len_err;

    always #5 iclk = ~iclk;

    packet_tx_reader dut (
        .iclk         (iclk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (fifo_rd),
        .i_fifo_len   (fifo_len),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_tx_en      (tx_en),
        .o_txd        (txd),
        .o_busy       (busy),
        .o_pkt_done   (pkt_done),
        .o_len_err    (len_err)
    );

    // Length FIFO with registered read; RAM preloaded with addr[7:0], one-cycle read.
    logic [11:0] len_mem [64];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic [7:0]  ram [DEPTH];

    initial for (int a = 0; a < DEPTH; a++) ram[a] = a[7:0];

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge iclk) begin
        rd_data <= ram[rd_addr];
        if (fifo_rd && !fifo_empty) begin
            fifo_len <= len_mem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // Line monitor, sampled on the falling edge.
    int         cyc = 0;
    int         rd_cnt = 0, len_err_cnt = 0, done_bad = 0, rd_empty_bad = 0;
    int         last_rd_cyc = 0, idle_run = 0, cur_len = 0;
    logic       prev_tx = 1'b0, prev_done = 1'b0;
    bit         have_prev = 1'b0;
    logic [7:0] frame_bytes [$];
    int         frame_off [$];
    int         frame_lens [$];
    int         gaps [$];
    int         lats [$];

    always @(negedge iclk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (fifo_empty) rd_empty_bad <= rd_empty_bad + 1;
        end
        if (len_err) len_err_cnt <= len_err_cnt + 1;
        if (tx_en) begin
            if (!prev_tx) begin
                frame_off.push_back(frame_bytes.size());
                lats.push_back(cyc - last_rd_cyc);
                if (have_prev) gaps.push_back(idle_run);
                cur_len <= 1;
            end else begin
                cur_len <= cur_len + 1;
            end
            frame_bytes.push_back(txd);
            if (prev_done) done_bad <= done_bad + 1;
        end else begin
            if (prev_tx) begin
                frame_lens.push_back(cur_len);
                if (!prev_done && i_rst_n) done_bad <= done_bad + 1;
                have_prev <= i_rst_n;
                idle_run  <= 1;
            end else begin
                idle_run <= idle_run + 1;
            end
            if (pkt_done) done_bad <= done_bad + 1;
        end
        prev_tx   <= tx_en;
        prev_done <= pkt_done;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_len(input int l);
        len_mem[wr_idx] = l[11:0];
        wr_idx = wr_idx + 1;
    endtask

    function automatic int adv(input int p, input int l);
        return (p + l) % DEPTH;
    endfunction

    function automatic bit legal(input int l);
        return (l >= 64) && (l <= 1536);
    endfunction

    function automatic int last_gap();
        return (gaps.size() == 0) ? -1 : gaps[$];
    endfunction

    function automatic int last_lat();
        return (lats.size() == 0) ? -1 : lats[$];
    endfunction

    // Reference frame: 7 x 0x55, 0xD5, then RAM bytes from the start pointer, wrapping at DEPTH.
    task automatic check_frame(input string tag, input int idx, input int start, input int len);
        int errs;
        int n;
        int e;
        errs = 0;
        if (idx >= frame_lens.size()) begin
            check({tag, "_present"}, frame_lens.size(), idx + 1);
            return;
        end
        check({tag, "_len"}, frame_lens[idx], len + 8);
        n = (frame_lens[idx] < len + 8) ? frame_lens[idx] : len + 8;
        for (int k = 0; k < n; k++) begin
            if (k < 7)       e = 8'h55;
            else if (k == 7) e = 8'hD5;
            else             e = ((start + k - 8) % DEPTH) % 256;
            if (frame_bytes[frame_off[idx] + k] !== e[7:0]) errs++;
        end
        check({tag, "_byte_errs"}, errs, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge iclk);
        while (!(busy === 1'b0 && fifo_empty) && n < budget) begin
            @(negedge iclk);
            n++;
        end
        check({tag, "_idle_in_time"}, (n < budget), 1);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge iclk);
        while (tx_en !== 1'b1 && n < budget) begin
            @(negedge iclk);
            n++;
        end
        check({tag, "_tx_in_time"}, (n < budget), 1);
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge iclk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge iclk);
            n++;
        end
        check({tag, "_done_in_time"}, (n < budget), 1);
    endtask

    initial begin
        int ref_ptr;
        int ef;
        int err0;
        int rd0;
        int l;
        int rlens [$];

        ref_ptr = 0;
        ef      = 0;

        repeat (3) @(negedge iclk);
        check("rst_tx_en", tx_en, 0);
        check("rst_txd", txd, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_done", pkt_done, 0);
        check("rst_len_err", len_err, 0);
        i_rst_n  = 1'b1;
        i_enable = 1'b1;

        // Single minimum-length frame.
        push_len(64);
        wait_idle("t1", 400);
        check("t1_frames", frame_lens.size(), ef + 1);
        check_frame("t1", ef, ref_ptr, 64);
        ef++;
        ref_ptr = adv(ref_ptr, 64);
        check("t1_latency", last_lat(), 3);
        check("t1_ptr", rd_addr, ref_ptr);

        // Back-to-back min and max frames.
        push_len(64);
        push_len(1536);
        wait_idle("t2", 2500);
        check("t2_frames", frame_lens.size(), ef + 2);
        check_frame("t2a", ef, ref_ptr, 64);
        ef++;
        ref_ptr = adv(ref_ptr, 64);
        check_frame("t2b", ef, ref_ptr, 1536);
        ef++;
        ref_ptr = adv(ref_ptr, 1536);
        check("t2_gap", last_gap(), 12);
        check("t2_ptr", rd_addr, ref_ptr);

        // Bring the pointer to 3040, then a frame that wraps the RAM.
        push_len(1376);
        wait_idle("t3a", 2000);
        check_frame("t3a", ef, ref_ptr, 1376);
        ef++;
        ref_ptr = adv(ref_ptr, 1376);
        check("t3_preset_ptr", rd_addr, 3040);
        push_len(64);
        wait_idle("t3b", 400);
        check("t3_frames", frame_lens.size(), ef + 1);
        check_frame("t3b", ef, ref_ptr, 64);
        ef++;
        ref_ptr = adv(ref_ptr, 64);
        check("t3_ptr", rd_addr, 32);

        // Bad lengths are skipped silently apart from the error pulse.
        err0 = len_err_cnt;
        push_len(10);
        push_len(0);
        push_len(2000);
        wait_idle("t4", 300);
        ref_ptr = adv(adv(adv(ref_ptr, 10), 0), 2000);
        check("t4_len_err", len_err_cnt - err0, 3);
        check("t4_frames", frame_lens.size(), ef);
        check("t4_ptr", rd_addr, ref_ptr);

        // Random mix of legal and illegal lengths.
        err0 = len_err_cnt;
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 3))
                0:       l = $urandom_range(0, 63);
                1:       l = $urandom_range(1537, 4095);
                default: l = $urandom_range(64, 400);
            endcase
            rlens.push_back(l);
            push_len(l);
        end
        wait_idle("rnd", 8000);
        l = 0;
        for (int r = 0; r < rlens.size(); r++) begin
            if (legal(rlens[r])) begin
                check_frame("rnd", ef, ref_ptr, rlens[r]);
                ef++;
            end else begin
                l++;
            end
            ref_ptr = adv(ref_ptr, rlens[r]);
        end
        check("rnd_frames", frame_lens.size(), ef);
        check("rnd_len_err", len_err_cnt - err0, l);
        check("rnd_ptr", rd_addr, ref_ptr);

        // Asynchronous reset in the middle of the data phase.
        push_len(200);
        wait_tx("t5", 100);
        repeat (20) @(negedge iclk);
        #2 i_rst_n = 1'b0;
        #1;
        check("t5_tx_en", tx_en, 0);
        check("t5_busy", busy, 0);
        check("t5_addr", rd_addr, 0);
        @(negedge iclk);
        @(posedge iclk);
        #3 i_rst_n = 1'b1;
        ef++;
        ref_ptr = 0;
        push_len(64);
        wait_idle("t5", 400);
        check("t5_frames", frame_lens.size(), ef + 1);
        check_frame("t5", ef, ref_ptr, 64);
        ef++;
        ref_ptr = adv(ref_ptr, 64);
        check("t5_ptr", rd_addr, ref_ptr);

        // Enable gating: no pop while disabled; dropping enable mid-frame finishes the frame.
        @(negedge iclk);
        i_enable = 1'b0;
        rd0 = rd_cnt;
        push_len(64);
        repeat (30) @(negedge iclk);
        check("t6_no_pop", rd_cnt, rd0);
        check("t6_idle", busy, 0);
        push_len(64);
        i_enable = 1'b1;
        wait_tx("t6", 50);
        repeat (30) @(negedge iclk);
        i_enable = 1'b0;
        wait_not_busy("t6", 200);
        repeat (40) @(negedge iclk);
        check("t6_pops", rd_cnt, rd0 + 1);
        check("t6_stays_idle", busy, 0);
        check("t6_frames", frame_lens.size(), ef + 1);
        check_frame("t6", ef, ref_ptr, 64);
        ef++;
        ref_ptr = adv(ref_ptr, 64);
        check("t6_ptr", rd_addr, ref_ptr);
        check("t6_fifo_left", fifo_empty, 0);

        check("pkt_done_placement", done_bad, 0);
        check("pop_while_empty", rd_empty_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
